// File: rtl/hdmi_test.sv
// 640x480@60 timing generator with colour-bar pattern.
// Pixel clock is clk/2; counters step on the pixclk high phase.
module hdmi_test #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int BAR_W    = 80
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pixclk,
   output logic [7:0] red_o,
   output logic [7:0] green_o,
   output logic [7:0] blue_o,
   output logic [9:0] counterX_o,
   output logic [9:0] counterY_o,
   output logic       hSync_o,
   output logic       vSync_o,
   output logic       drawArea_o
);

   localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic       pixReg;
   logic [9:0] counterX;
   logic [9:0] counterY;
   logic [2:0] bar;
   logic       drawArea;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixReg   <= 1'b0;
         counterX <= '0;
         counterY <= '0;
      end else begin
         pixReg <= ~pixReg;
         if (pixReg) begin
            if (counterX == H_LAST) begin
               counterX <= '0;
               if (counterY == V_LAST) begin
                  counterY <= '0;
               end else begin
                  counterY <= counterY + 10'd1;
               end
            end else begin
               counterX <= counterX + 10'd1;
            end
         end
      end
   end

   // Bar index by threshold comparison, avoiding a divider.
   always_comb begin
      bar = '0;
      for (int i = 1; i < 8; i++) begin
         if (counterX >= 10'(i * BAR_W)) begin
            bar = 3'(i);
         end
      end
   end

   assign drawArea = (counterX < H_VIS) && (counterY < V_VIS);

   assign pixclk     = pixReg;
   assign counterX_o = counterX;
   assign counterY_o = counterY;
   assign drawArea_o = drawArea;
   assign hSync_o    = !((counterX >= HS_BEG) && (counterX < HS_END));
   assign vSync_o    = !((counterY >= VS_BEG) && (counterY < VS_END));
   assign red_o      = (drawArea && bar[1]) ? 8'hFF : 8'h00;
   assign green_o    = (drawArea && bar[2]) ? 8'hFF : 8'h00;
   assign blue_o     = (drawArea && bar[0]) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_hdmi_test.sv
// Directed bench for hdmi_test: full-size instance for line timing and
// colours, miniature instance for whole-frame vertical behaviour.
module tb_hdmi_test;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       pcA, hsA, vsA, daA;
   logic [7:0] rA, gA, bA;
   logic [9:0] xA, yA;

   logic       pcB, hsB, vsB, daB;
   logic [7:0] rB, gB, bB;
   logic [9:0] xB, yB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hdmi_test dutA (
      .clk(clk), .rst_n(rst_n), .pixclk(pcA),
      .red_o(rA), .green_o(gA), .blue_o(bA),
      .counterX_o(xA), .counterY_o(yA),
      .hSync_o(hsA), .vSync_o(vsA), .drawArea_o(daA)
   );

   // 16x8 total: active 8x4, hsync X=10..12, vsync Y=5..6, 1-pixel bars
   hdmi_test #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .BAR_W(1)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .pixclk(pcB),
      .red_o(rB), .green_o(gB), .blue_o(bB),
      .counterX_o(xB), .counterY_o(yB),
      .hSync_o(hsB), .vSync_o(vsB), .drawArea_o(daB)
   );

   // Wait (sampling on negedge) until the chosen instance is at (x,y).
   task automatic waitPos(input bit useB, input int x, input int y,
                          input int budget);
      bit hit;
      hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (useB) hit = (xB == 10'(x)) && (yB == 10'(y));
         else      hit = (xA == 10'(x)) && (yA == 10'(y));
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL waitPos: (%0d,%0d) not reached in %0d clk, now A=(%0d,%0d) B=(%0d,%0d)",
                  x, y, budget, xA, yA, xB, yB);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pcA, xA, yA} !== 21'd0) begin
         errors++;
         $display("FAIL reset_state: pc=%b x=%0d y=%0d expected 0 0 0", pcA, xA, yA);
      end
      checks++;
      if ({daA, hsA, vsA, rA, gA, bA} !== {3'b111, 24'h0}) begin
         errors++;
         $display("FAIL reset_outputs: da=%b hs=%b vs=%b rgb=%h%h%h expected 1 1 1 000000",
                  daA, hsA, vsA, rA, gA, bA);
      end
      checks++;
      if ({pcB, xB, yB} !== 21'd0) begin
         errors++;
         $display("FAIL reset_state_B: pc=%b x=%0d y=%0d expected 0 0 0", pcB, xB, yB);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pcA !== 1'b1 || xA !== 10'd0) begin
         errors++;
         $display("FAIL edge1: pc=%b x=%0d expected 1 0", pcA, xA);
      end
      @(posedge clk); #1;
      checks++;
      if (pcA !== 1'b0 || xA !== 10'd1) begin
         errors++;
         $display("FAIL edge2: pc=%b x=%0d expected 0 1", pcA, xA);
      end
      @(posedge clk); #1;
      checks++;
      if (pcA !== 1'b1 || xA !== 10'd1) begin
         errors++;
         $display("FAIL edge3_hold: pc=%b x=%0d expected 1 1", pcA, xA);
      end
      @(posedge clk); #1;
      checks++;
      if (pcA !== 1'b0 || xA !== 10'd2) begin
         errors++;
         $display("FAIL edge4: pc=%b x=%0d expected 0 2", pcA, xA);
      end
   endtask

   task automatic test_black;
      waitPos(0, 10, 10, 20000);
      checks++;
      if ({rA, gA, bA} !== 24'h0 || {daA, hsA, vsA} !== 3'b111) begin
         errors++;
         $display("FAIL black_10_10: rgb=%h%h%h da=%b hs=%b vs=%b expected 000000 1 1 1",
                  rA, gA, bA, daA, hsA, vsA);
      end
   endtask

   task automatic test_hsweep;
      int posErr = 0, hsErr = 0, daErr = 0, vsErr = 0, hsClk = 0;
      waitPos(0, 0, 11, 4000);
      for (int p = 0; p < 800; p++) begin
         if (xA !== 10'(p) || yA !== 10'd11) posErr++;
         if (hsA !== !(p >= 656 && p <= 751)) hsErr++;
         if (daA !== (p < 640)) daErr++;
         if (vsA !== 1'b1) vsErr++;
         for (int c = 0; c < 2; c++) begin
            if (hsA === 1'b0) hsClk++;
            @(negedge clk);
         end
      end
      checks++;
      if (posErr != 0) begin
         errors++;
         $display("FAIL hsweep_pos: %0d pixel position errors, expected 0", posErr);
      end
      checks++;
      if (hsErr != 0) begin
         errors++;
         $display("FAIL hsweep_hsync: %0d pixels wrong, expected low only X=656..751", hsErr);
      end
      checks++;
      if (hsClk != 192) begin
         errors++;
         $display("FAIL hsync_width: %0d clk low, expected 192", hsClk);
      end
      checks++;
      if (daErr != 0) begin
         errors++;
         $display("FAIL hsweep_draw: %0d pixels wrong, expected high for X<640", daErr);
      end
      checks++;
      if (vsErr != 0) begin
         errors++;
         $display("FAIL hsweep_vsync: %0d pixels low, expected 0", vsErr);
      end
      checks++;
      if (xA !== 10'd0 || yA !== 10'd12) begin
         errors++;
         $display("FAIL hwrap: x=%0d y=%0d expected 0 12", xA, yA);
      end
   endtask

   task automatic test_colour_bars;
      int xs[8] = '{80, 160, 240, 320, 400, 480, 639, 640};
      logic [23:0] exp[8] = '{24'h0000FF, 24'hFF0000, 24'hFF00FF, 24'h00FF00,
                              24'h00FFFF, 24'hFFFF00, 24'hFFFFFF, 24'h000000};
      for (int i = 0; i < 8; i++) begin
         waitPos(0, xs[i], 12, 2000);
         checks++;
         if ({rA, gA, bA} !== exp[i]) begin
            errors++;
            $display("FAIL bar_x%0d: rgb=%h%h%h expected %h", xs[i], rA, gA, bA, exp[i]);
         end
      end
      // Last pixel before a bar edge still shows the previous bar
      waitPos(0, 79, 13, 4000);
      checks++;
      if ({rA, gA, bA} !== 24'h0) begin
         errors++;
         $display("FAIL bar_x79: rgb=%h%h%h expected 000000", rA, gA, bA);
      end
   endtask

   task automatic test_small_frame;
      int hsErr = 0, vsErr = 0, daErr = 0, rgbErr = 0, clkCnt = 0;
      logic [23:0] e;
      waitPos(1, 0, 0, 400);
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 16; x++) begin
            if (hsB !== !(x >= 10 && x <= 12)) hsErr++;
            if (vsB !== !(y >= 5 && y <= 6)) vsErr++;
            if (daB !== (x < 8 && y < 4)) daErr++;
            e = 24'h0;
            if (x < 8 && y < 4) begin
               if (x[1]) e[23:16] = 8'hFF;
               if (x[2]) e[15:8]  = 8'hFF;
               if (x[0]) e[7:0]   = 8'hFF;
            end
            if ({rB, gB, bB} !== e) rgbErr++;
            if (xB !== 10'(x) || yB !== 10'(y)) rgbErr++;
            repeat (2) @(negedge clk);
            clkCnt += 2;
         end
      end
      checks++;
      if (hsErr != 0) begin
         errors++;
         $display("FAIL small_hsync: %0d pixels wrong, expected low X=10..12", hsErr);
      end
      checks++;
      if (vsErr != 0) begin
         errors++;
         $display("FAIL small_vsync: %0d pixels wrong, expected low Y=5..6", vsErr);
      end
      checks++;
      if (daErr != 0) begin
         errors++;
         $display("FAIL small_draw: %0d pixels wrong, expected 0", daErr);
      end
      checks++;
      if (rgbErr != 0) begin
         errors++;
         $display("FAIL small_rgb_pos: %0d pixels wrong, expected 0", rgbErr);
      end
      checks++;
      if (xB !== 10'd0 || yB !== 10'd0 || clkCnt != 256) begin
         errors++;
         $display("FAIL small_vwrap: x=%0d y=%0d clk=%0d expected 0 0 256", xB, yB, clkCnt);
      end
   endtask

   task automatic test_reset_mid;
      waitPos(0, 300, 13, 4000);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pcA, xA, yA} !== 21'd0 || {pcB, xB, yB} !== 21'd0) begin
         errors++;
         $display("FAIL async_reset: A pc=%b x=%0d y=%0d B x=%0d y=%0d expected all 0",
                  pcA, xA, yA, xB, yB);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (pcA !== 1'b0 || xA !== 10'd1 || yA !== 10'd0) begin
         errors++;
         $display("FAIL resume: pc=%b x=%0d y=%0d expected 0 1 0", pcA, xA, yA);
      end
   endtask

   initial begin
      test_reset();
      test_small_frame();
      test_black();
      test_hsweep();
      test_colour_bars();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hdmi_test.md
Name: hdmi_test

Overview:
- 640x480 @ 60 Hz video timing generator with a built-in colour-bar test pattern, driving the RGB/sync side of an HDMI/DVI transmitter.
- Derives a pixel clock by dividing the system clock by 2.
- Keeps horizontal/vertical pixel counters and produces negative-polarity syncs, a draw-area flag and 24-bit RGB.
- Sits between the board clock and the TMDS encoder stage; the encoders are outside this block.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- BAR_W, 80, colour-bar width in pixels

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- pixclk  out  1  pixel clock, clk/2, registered toggle
- red_o  out  8  pixel red
- green_o  out  8  pixel green
- blue_o  out  8  pixel blue
- counterX_o  out  10  horizontal position, 0..H_TOTAL-1
- counterY_o  out  10  vertical position, 0..V_TOTAL-1
- hSync_o  out  1  horizontal sync, active low
- vSync_o  out  1  vertical sync, active low
- drawArea_o  out  1  high inside the visible region

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Reset (rst_n low, asynchronous):
  - pixclk=0, counterX=0, counterY=0.
  - Combinational outputs therefore read drawArea_o=1, hSync_o=1, vSync_o=1, RGB=0.
- Pixel clock and pixel period:
  - pixclk register toggles on every clk rising edge when not in reset.
  - Counters advance only on a clk edge where pixclk is currently 1. Each pixel therefore lasts 2 clk cycles, and counters change together with the pixclk 1->0 transition.
  - First counter advance occurs on the 2nd clk edge after reset release.
- Horizontal counter:
  - counterX increments by 1.
  - At H_TOTAL-1 (799) it wraps to 0 and counterY increments.
- Vertical counter:
  - counterY wraps to 0 when counterX wraps while counterY = V_TOTAL-1 (524).
  - Both wraps occur on the same pixel advance.
- Sync and draw-area decode (combinational from the registered counters, so they are aligned with the counter outputs in the same cycle):
  - hSync_o = 0 iff H_ACTIVE+H_FP <= counterX < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vSync_o = 0 iff V_ACTIVE+V_FP <= counterY < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - drawArea_o = (counterX < H_ACTIVE) && (counterY < V_ACTIVE).
- Colour (combinational, aligned with the counters):
  - When drawArea_o=0, RGB = 0.
  - Otherwise bar index b = floor(counterX / BAR_W), 0..7. Implement with comparators; no divider.
  - red_o = b[1] ? 8'hFF : 0; green_o = b[2] ? 8'hFF : 0; blue_o = b[0] ? 8'hFF : 0.
  - Bar order: black, blue, red, magenta, green, cyan, yellow, white.
- Width rules: counters are 10-bit unsigned and never exceed 799/524. Compare ranges use unsigned arithmetic.
- Reset mid-frame: all state returns to 0 immediately (asynchronous). Timing restarts cleanly at (0,0) after release.
- No inputs other than clk/rst_n; the pattern is static frame to frame.

Test Plan:
- Reset then release -> pixclk toggles every clk edge; counterX goes 0->1 on the 2nd clk edge; each X value is held 2 clk cycles; at (0,0) RGB=0,0,0 and drawArea_o=1.
- Run to counterX=10, counterY=10 -> RGB = 0,0,0 (black bar), drawArea_o=1, hSync_o=1, vSync_o=1.
- Horizontal sweep -> hSync_o low exactly for X=656..751 (96 pixels = 192 clk); drawArea_o falls at X=640; counterX wraps 799->0 with counterY +1.
- Full frame -> vSync_o low for Y=490..491 only; counterY wraps 524->0 coincident with counterX 799->0; frame = 800*525*2 = 840000 clk.
- Colour bars on line 0:
  - X=80 -> 0,0,FF; X=160 -> FF,0,0; X=240 -> FF,0,FF; X=320 -> 0,FF,0.
  - X=400 -> 0,FF,FF; X=480 -> FF,FF,0; X=639 -> FF,FF,FF.
  - X=640 or Y=480 -> 0,0,0.
- Assert rst_n low at X=300, Y=200 -> counters and pixclk go to 0 without waiting for a clk edge; normal timing resumes from (0,0) after release.
